// File: rtl/herald_cmd_seq.sv
// herald_cmd_seq: byte-wide host command sequencer.
// The host writes a command byte ([7:6] operand count, [5:4] result word
// count, [3:0] opcode), then the operand bytes, LSB first. The block raises
// eng_req until the engine pulses eng_ack, then streams the result words,
// LSB first, into a byte FIFO that the host drains with read strobes.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   ui_in[7:0]            host write data
//   wr_strobe, rd_strobe  host strobes (level; rising edges are acted on)
//   data_out[7:0]         last popped result byte (registered)
//   status_out[7:0]       {busy, fifo_nonempty, err_timeout, err_underflow,
//                          err_cmd, fifo_full, 2'b00}
//   eng_req               engine request, held until ack or timeout
//   eng_opcode[3:0]       opcode of the latched command
//   eng_operands          operand k in slice k
//   eng_ack, eng_result   engine completion pulse and result words
//
// state    | meaning
// IDLE     | waiting for a command byte
// OPERANDS | collecting N*OP_BYTES operand bytes
// ISSUE    | raising eng_req, loading the timeout counter
// WAIT     | waiting for eng_ack or timeout
// PUSH     | moving R*OP_BYTES result bytes into the FIFO
module herald_cmd_seq #(
   parameter int OP_BYTES       = 3,
   parameter int MAX_OPERANDS   = 2,
   parameter int MAX_RES_WORDS  = 3,
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic [7:0] ui_in,
   input  logic wr_strobe,
   input  logic rd_strobe,
   output logic [7:0] data_out,
   output logic [7:0] status_out,
   output logic eng_req,
   output logic [3:0] eng_opcode,
   output logic [8*OP_BYTES*(MAX_OPERANDS > 0 ? MAX_OPERANDS : 1)-1:0] eng_operands,
   input  logic eng_ack,
   input  logic [8*OP_BYTES*(MAX_RES_WORDS > 0 ? MAX_RES_WORDS : 1)-1:0] eng_result
);

   // A zero maximum still keeps one slot so the buses stay legal widths;
   // the command check prevents such a slot from ever being used.
   localparam int OP_SLOTS  = (MAX_OPERANDS > 0) ? MAX_OPERANDS : 1;
   localparam int RES_SLOTS = (MAX_RES_WORDS > 0) ? MAX_RES_WORDS : 1;
   localparam int OPW       = 8 * OP_BYTES * OP_SLOTS;
   localparam int RESW      = 8 * OP_BYTES * RES_SLOTS;
   localparam int OP_TOTAL  = OP_BYTES * OP_SLOTS;
   localparam int RES_TOTAL = OP_BYTES * RES_SLOTS;
   localparam int CNT_W     = $clog2(3 * OP_BYTES + 1);
   localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int FCNT_W    = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_OPERANDS, S_ISSUE, S_WAIT, S_PUSH
   } state_t;

   state_t state_q, state_d;
   logic [7:0] cmd_q, cmd_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [OPW-1:0] operands_q, operands_d;
   logic [RESW-1:0] result_q, result_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic eng_req_q, eng_req_d;
   logic wr_prev_q, rd_prev_q;
   logic err_tmo_q, err_tmo_d;
   logic err_unf_q, err_unf_d;
   logic err_cmd_q, err_cmd_d;
   logic [7:0] data_out_q, data_out_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [7:0] fifo_mem_q [FIFO_DEPTH];

   logic wr_edge, rd_edge;
   logic cmd_bad;
   logic fifo_full, fifo_empty;
   logic push, pop;
   logic [7:0] res_byte;
   logic [CNT_W-1:0] op_last, res_last;

   assign wr_edge    = wr_strobe & ~wr_prev_q;
   assign rd_edge    = rd_strobe & ~rd_prev_q;
   assign cmd_bad    = (int'(ui_in[7:6]) > MAX_OPERANDS) || (int'(ui_in[5:4]) > MAX_RES_WORDS);
   assign fifo_full  = (fcnt_q == FCNT_W'(FIFO_DEPTH));
   assign fifo_empty = (fcnt_q == '0);
   assign op_last    = CNT_W'(cmd_q[7:6]) * CNT_W'(OP_BYTES) - CNT_W'(1);
   assign res_last   = CNT_W'(cmd_q[5:4]) * CNT_W'(OP_BYTES) - CNT_W'(1);

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cmd_q      <= '0;
         byte_cnt_q <= '0;
         operands_q <= '0;
         result_q   <= '0;
         tmo_q      <= '0;
         eng_req_q  <= 1'b0;
         wr_prev_q  <= 1'b0;
         rd_prev_q  <= 1'b0;
         err_tmo_q  <= 1'b0;
         err_unf_q  <= 1'b0;
         err_cmd_q  <= 1'b0;
         data_out_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         byte_cnt_q <= byte_cnt_d;
         operands_q <= operands_d;
         result_q   <= result_d;
         tmo_q      <= tmo_d;
         eng_req_q  <= eng_req_d;
         wr_prev_q  <= wr_strobe;
         rd_prev_q  <= rd_strobe;
         err_tmo_q  <= err_tmo_d;
         err_unf_q  <= err_unf_d;
         err_cmd_q  <= err_cmd_d;
         data_out_q <= data_out_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fcnt_q     <= fcnt_d;
      end
   end

   // FIFO storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= res_byte;
      end
   end

   // next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (wr_edge && (ui_in != 8'h00) && !cmd_bad) begin
               state_d = (ui_in[7:6] != 2'b00) ? S_OPERANDS : S_ISSUE;
            end
         end
         S_OPERANDS: begin
            if (wr_edge && (byte_cnt_q == op_last)) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (eng_ack) begin
               state_d = (cmd_q[5:4] != 2'b00) ? S_PUSH : S_IDLE;
            end else if (tmo_q == '0) begin
               state_d = S_IDLE;
            end
         end
         S_PUSH: begin
            if (!fifo_full && (byte_cnt_q == res_last)) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      res_byte = '0;
      for (int i = 0; i < RES_TOTAL; i++) begin
         if (byte_cnt_q == CNT_W'(i)) begin
            res_byte = result_q[i*8 +: 8];
         end
      end
   end

   // datapath next values
   always_comb begin
      cmd_d      = cmd_q;
      byte_cnt_d = byte_cnt_q;
      operands_d = operands_q;
      result_d   = result_q;
      tmo_d      = tmo_q;
      eng_req_d  = eng_req_q;
      err_tmo_d  = err_tmo_q;
      err_unf_d  = err_unf_q;
      err_cmd_d  = err_cmd_q;
      data_out_d = data_out_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      push       = 1'b0;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (wr_edge) begin
               if (ui_in == 8'h00) begin
                  err_tmo_d = 1'b0;
                  err_unf_d = 1'b0;
                  err_cmd_d = 1'b0;
               end else if (cmd_bad) begin
                  err_cmd_d = 1'b1;
               end else begin
                  cmd_d      = ui_in;
                  byte_cnt_d = '0;
               end
            end
         end
         S_OPERANDS: begin
            if (wr_edge) begin
               for (int i = 0; i < OP_TOTAL; i++) begin
                  if (byte_cnt_q == CNT_W'(i)) begin
                     operands_d[i*8 +: 8] = ui_in;
                  end
               end
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
         end
         S_ISSUE: begin
            eng_req_d = 1'b1;
            tmo_d     = TMO_W'(TIMEOUT_CYCLES - 1);
         end
         S_WAIT: begin
            // An ack on the terminal cycle still counts as a completion.
            if (eng_ack) begin
               result_d   = eng_result;
               eng_req_d  = 1'b0;
               byte_cnt_d = '0;
            end else if (tmo_q == '0) begin
               eng_req_d = 1'b0;
               err_tmo_d = 1'b1;
            end else begin
               tmo_d = tmo_q - TMO_W'(1);
            end
         end
         S_PUSH: begin
            // Fullness is judged before any same-cycle pop, so a pop
            // frees space for the following cycle.
            if (!fifo_full) begin
               push       = 1'b1;
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase

      if (wr_edge && ((state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_PUSH))) begin
         err_cmd_d = 1'b1;
      end

      if (rd_edge) begin
         if (!fifo_empty) begin
            pop        = 1'b1;
            data_out_d = fifo_mem_q[rd_ptr_q];
         end else begin
            data_out_d = 8'h00;
            err_unf_d  = 1'b1;
         end
      end

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      fcnt_d = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);
   end

   // outputs
   always_comb begin
      status_out   = {(state_q != S_IDLE), !fifo_empty, err_tmo_q, err_unf_q,
                      err_cmd_q, fifo_full, 2'b00};
      data_out     = data_out_q;
      eng_req      = eng_req_q;
      eng_opcode   = cmd_q[3:0];
      eng_operands = operands_q;
   end

endmodule

// File: tb/tb_herald_cmd_seq.sv
// Bench for herald_cmd_seq. Three instances share clock and reset:
// dut 0 uses defaults, dut 1 a 4-deep FIFO, dut 2 a 16-cycle timeout.
module tb_herald_cmd_seq;

   logic clk;
   logic rst_n;
   logic [7:0]  ui_in_v [3];
   logic        wr_v    [3];
   logic        rd_v    [3];
   logic        ack_v   [3];
   logic [71:0] res_v   [3];
   logic [7:0]  dout_v  [3];
   logic [7:0]  stat_v  [3];
   logic        req_v   [3];
   logic [3:0]  opc_v   [3];
   logic [47:0] opnd_v  [3];

   int n_total = 0;
   int n_pass  = 0;
   logic [7:0] exp_q [$];

   herald_cmd_seq dut0 (
      .clk(clk), .rst_n(rst_n), .ui_in(ui_in_v[0]), .wr_strobe(wr_v[0]),
      .rd_strobe(rd_v[0]), .data_out(dout_v[0]), .status_out(stat_v[0]),
      .eng_req(req_v[0]), .eng_opcode(opc_v[0]), .eng_operands(opnd_v[0]),
      .eng_ack(ack_v[0]), .eng_result(res_v[0]));

   herald_cmd_seq #(.FIFO_DEPTH(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .ui_in(ui_in_v[1]), .wr_strobe(wr_v[1]),
      .rd_strobe(rd_v[1]), .data_out(dout_v[1]), .status_out(stat_v[1]),
      .eng_req(req_v[1]), .eng_opcode(opc_v[1]), .eng_operands(opnd_v[1]),
      .eng_ack(ack_v[1]), .eng_result(res_v[1]));

   herald_cmd_seq #(.TIMEOUT_CYCLES(16)) dut2 (
      .clk(clk), .rst_n(rst_n), .ui_in(ui_in_v[2]), .wr_strobe(wr_v[2]),
      .rd_strobe(rd_v[2]), .data_out(dout_v[2]), .status_out(stat_v[2]),
      .eng_req(req_v[2]), .eng_opcode(opc_v[2]), .eng_operands(opnd_v[2]),
      .eng_ack(ack_v[2]), .eng_result(res_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wr_byte(input int d, input logic [7:0] b);
      @(negedge clk);
      ui_in_v[d] = b;
      wr_v[d] = 1'b1;
      @(negedge clk);
      wr_v[d] = 1'b0;
   endtask

   // Pops the scoreboard; an empty scoreboard means an underflow read (0x00).
   task automatic rd_pop(input int d, input string tag);
      logic [7:0] e;
      @(negedge clk);
      rd_v[d] = 1'b1;
      @(negedge clk);
      rd_v[d] = 1'b0;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      check(tag, 72'(dout_v[d]), 72'(e));
   endtask

   task automatic ack(input int d, input logic [71:0] result, input int r_words);
      @(negedge clk);
      res_v[d] = result;
      ack_v[d] = 1'b1;
      for (int i = 0; i < r_words * 3; i++) exp_q.push_back(result[i*8 +: 8]);
      @(negedge clk);
      ack_v[d] = 1'b0;
   endtask

   task automatic wait_req(input int d, input logic val, input string tag);
      int n = 0;
      while (req_v[d] !== val && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(tag, 72'(req_v[d]), 72'(val));
   endtask

   task automatic wait_idle(input int d, input string tag);
      int n = 0;
      while (stat_v[d][7] !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, 72'(stat_v[d][7]), 72'h0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ui_in_v[i] = 8'h00; wr_v[i] = 1'b0; rd_v[i] = 1'b0;
         ack_v[i] = 1'b0; res_v[i] = '0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_data_out", 72'(dout_v[0]), 72'h00);
      check("rst_status",   72'(stat_v[0]), 72'h00);
      check("rst_eng_req",  72'(req_v[0]),  72'h0);
      check("rst_operands", 72'(opnd_v[0]), 72'h0);
      check("rst_status_d1", 72'(stat_v[1]), 72'h00);

      // Multiply-style command: 2 operands, 1 result word, opcode 1.
      wr_byte(0, 8'h91);
      wr_byte(0, 8'h00); wr_byte(0, 8'h10); wr_byte(0, 8'h00);
      wr_byte(0, 8'h00); wr_byte(0, 8'h20); wr_byte(0, 8'h00);
      check("mul_operands", 72'(opnd_v[0]), 72'h002000_001000);
      check("mul_opcode",   72'(opc_v[0]),  72'h1);
      wait_req(0, 1'b1, "mul_req_rise");
      check("mul_busy", 72'(stat_v[0][7]), 72'h1);
      ack(0, 72'h002000, 1);
      wait_req(0, 1'b0, "mul_req_fall");
      wait_idle(0, "mul_idle");
      check("mul_nonempty", 72'(stat_v[0][6]), 72'h1);
      rd_pop(0, "mul_rd0");
      rd_pop(0, "mul_rd1");
      rd_pop(0, "mul_rd2");
      check("mul_empty", 72'(stat_v[0][6]), 72'h0);

      // Operand count above the maximum.
      wr_byte(0, 8'hC0);
      check("bad_cmd_status", 72'(stat_v[0]), 72'h08);
      repeat (3) @(negedge clk);
      check("bad_cmd_no_req", 72'(req_v[0]), 72'h0);
      wr_byte(0, 8'h00);
      check("clear_status", 72'(stat_v[0]), 72'h00);

      // Write during WAIT is flagged; the ack is still honoured.
      wr_byte(0, 8'h10);
      wait_req(0, 1'b1, "wwait_req_rise");
      wr_byte(0, 8'h55);
      check("wwait_status", 72'(stat_v[0]), 72'h88);
      check("wwait_req_held", 72'(req_v[0]), 72'h1);
      ack(0, 72'hABCDEF, 1);
      wait_idle(0, "wwait_idle");
      rd_pop(0, "wwait_rd0");
      rd_pop(0, "wwait_rd1");
      rd_pop(0, "wwait_rd2");
      check("wwait_final_status", 72'(stat_v[0]), 72'h08);
      wr_byte(0, 8'h00);

      // Normalize-style command against a 4-deep FIFO.
      wr_byte(1, 8'hB3);
      wr_byte(1, 8'h11); wr_byte(1, 8'h22); wr_byte(1, 8'h33);
      wr_byte(1, 8'h44); wr_byte(1, 8'h55); wr_byte(1, 8'h66);
      check("norm_operands", 72'(opnd_v[1]), 72'h665544_332211);
      check("norm_opcode",   72'(opc_v[1]),  72'h3);
      wait_req(1, 1'b1, "norm_req_rise");
      ack(1, 72'h030000_020000_010000, 3);
      repeat (8) @(negedge clk);
      check("norm_stall_status", 72'(stat_v[1]), 72'hC4);
      for (int i = 0; i < 9; i++) rd_pop(1, $sformatf("norm_rd%0d", i));
      wait_idle(1, "norm_idle");
      check("norm_final_status", 72'(stat_v[1]), 72'h00);
      rd_pop(1, "underflow_data");
      check("underflow_status", 72'(stat_v[1]), 72'h10);

      // Timeout with a 16-cycle limit.
      wr_byte(2, 8'h40);
      wr_byte(2, 8'h01); wr_byte(2, 8'h02); wr_byte(2, 8'h03);
      wait_req(2, 1'b1, "tmo_req_rise");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (req_v[2] === 1'b1 && n < 40);
      check("tmo_req_cycles", 72'(n), 72'd16);
      check("tmo_status", 72'(stat_v[2]), 72'h20);
      wr_byte(2, 8'h00);
      check("tmo_clear", 72'(stat_v[2]), 72'h00);

      // Reset during WAIT.
      wr_byte(0, 8'h10);
      wait_req(0, 1'b1, "rstw_req_rise");
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rstw_req",      72'(req_v[0]),  72'h0);
      check("rstw_status",   72'(stat_v[0]), 72'h00);
      check("rstw_operands", 72'(opnd_v[0]), 72'h0);
      ack(0, 72'h123456, 0);
      repeat (4) @(negedge clk);
      check("rstw_late_ack", 72'(stat_v[0]), 72'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
